// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath constants and operand source select encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - per-operand source select (x0, EX, WB, regfile) and mux.
module operand_fwd_mux #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AW   = riscv_pkg::AW
) (
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_fwd_en,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            wb_fwd_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);
  import riscv_pkg::*;

  fwd_sel_t sel;

  // EX is younger than WB, so it wins when both target the same register.
  always_comb begin
    sel = FWD_RF;
    if (rs == '0)
      sel = FWD_ZERO;
    else if (ex_fwd_en && ex_rd == rs)
      sel = FWD_EX;
    else if (wb_fwd_en && wb_rd == rs)
      sel = FWD_WB;
  end

  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_ZERO: operand = '0;
      FWD_EX:   operand = ex_result;
      FWD_WB:   operand = wb_data;
      default:  operand = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand resolution, hazard stall and pipeline register.
// Macro ID_EX_FWD_EN enables EX/WB forwarding; without it every RAW hazard stalls.
module id_ex_operand_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int AW     = riscv_pkg::AW,
  parameter int CTRL_W = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [AW-1:0]     id_rs1,
  input  logic [AW-1:0]     id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [AW-1:0]     id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   rf_dataA,
  input  logic [XLEN-1:0]   rf_dataB,
  input  logic              ex_valid,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic [AW-1:0]     ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              wb_regWrite,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_opA,
  output logic [XLEN-1:0]   out_opB,
  output logic [AW-1:0]     out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       stall_count
);

  logic [XLEN-1:0] opa, opb;
  logic            ex_fwd_en, wb_fwd_en, load_use, raw_ex;

  assign raw_ex = (id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2);

`ifdef ID_EX_FWD_EN
  assign ex_fwd_en = ex_valid && ex_regWrite && !ex_memRead;
  assign wb_fwd_en = wb_regWrite;
  assign load_use  = id_valid && ex_valid && ex_memRead && ex_rd != '0 && raw_ex;
`else
  logic raw_wb;
  assign raw_wb    = (id_rs1_used && wb_rd == id_rs1) || (id_rs2_used && wb_rd == id_rs2);
  assign ex_fwd_en = 1'b0;
  assign wb_fwd_en = 1'b0;
  // Without bypass paths any in-flight producer of a source register must drain first.
  assign load_use  = id_valid &&
                     ((ex_valid && (ex_memRead || ex_regWrite) && ex_rd != '0 && raw_ex) ||
                      (wb_regWrite && wb_rd != '0 && raw_wb));
`endif

  assign id_ready = flush || (!ex_stall && !load_use);

  operand_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_mux_a (
    .rs(id_rs1), .rf_data(rf_dataA),
    .ex_fwd_en(ex_fwd_en), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(opa)
  );

  operand_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_mux_b (
    .rs(id_rs2), .rf_data(rf_dataB),
    .ex_fwd_en(ex_fwd_en), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(opb)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      out_valid   <= 1'b0;
      out_opA     <= '0;
      out_opB     <= '0;
      out_rd      <= '0;
      out_ctrl    <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      stall_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!ex_stall) begin
      if (load_use) begin
        out_valid <= 1'b0;
        if (stall_count != '1)
          stall_count <= stall_count + 32'd1;
      end else begin
        out_valid <= id_valid;
        out_opA   <= opa;
        out_opB   <= opb;
        out_rd    <= id_rd;
        out_ctrl  <= id_ctrl;
        out_imm   <= id_imm;
        out_pc    <= id_pc;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - vector table, hazard sequences and random run against a reference model.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic        id_valid, id_ready, id_rs1_used, id_rs2_used;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, wb_rd, out_rd;
  logic [15:0] id_ctrl, out_ctrl;
  logic [31:0] id_imm, id_pc, rf_dataA, rf_dataB, ex_result, wb_data;
  logic        ex_valid, ex_regWrite, ex_memRead, wb_regWrite, ex_stall, flush;
  logic        out_valid;
  logic [31:0] out_opA, out_opB, out_imm, out_pc, stall_count;

  int total = 0;
  int bad   = 0;

  id_ex_operand_stage dut (
    .clock(clock), .clear(clear),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc(id_pc),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .out_valid(out_valid), .out_opA(out_opA), .out_opB(out_opB), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pc(out_pc), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_ctrl = 0; id_imm = 0; id_pc = 0; rf_dataA = 0; rf_dataB = 0;
    ex_valid = 0; ex_regWrite = 0; ex_memRead = 0; ex_rd = 0; ex_result = 0;
    wb_regWrite = 0; wb_rd = 0; wb_data = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    clear = 1;
    #2;
    clear = 0;
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  // Architectural value of register r as seen by the instruction in decode:
  // the youngest in-flight producer wins, x0 is always zero.
  function automatic logic [31:0] arch_val(input logic [4:0] r, input logic [31:0] rfv);
    if (r == 0) return 32'd0;
    if (ex_valid && ex_regWrite && ex_rd == r) return ex_result;
    if (wb_regWrite && wb_rd == r) return wb_data;
    return rfv;
  endfunction

  function automatic logic must_wait(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (ex_valid && ex_memRead && ex_rd == r) return 1'b1;
    if (!FWD && ex_valid && ex_regWrite && ex_rd == r) return 1'b1;
    if (!FWD && wb_regWrite && wb_rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic hazard();
    return id_valid && ((id_rs1_used && must_wait(id_rs1)) || (id_rs2_used && must_wait(id_rs2)));
  endfunction

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [31:0] rfa, rfb;
    logic        exv, exw, exm;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        rdy, vld;
    logic [31:0] a, b;
  } vec_t;

  vec_t vt[10];

  logic        m_valid, m_ua, m_ub;
  logic [31:0] m_a, m_b, m_imm, m_pc, m_cnt;
  logic [4:0]  m_rd;
  logic [15:0] m_ctrl;
  logic [31:0] rf[32];

  task automatic rand_cycle(input int n);
    logic hz;
    id_valid = ($urandom_range(0, 7) != 0);
    id_rs1 = 5'($urandom_range(0, 7));
    id_rs2 = 5'($urandom_range(0, 7));
    id_rs1_used = 1'($urandom_range(0, 1));
    id_rs2_used = 1'($urandom_range(0, 1));
    id_rd = 5'($urandom); id_ctrl = 16'($urandom); id_imm = $urandom; id_pc = $urandom;
    rf_dataA = rf[id_rs1];
    rf_dataB = rf[id_rs2];
    ex_valid = 1'($urandom_range(0, 1));
    ex_memRead = ($urandom_range(0, 3) == 0);
    ex_regWrite = ex_memRead || ($urandom_range(0, 2) != 0);
    ex_rd = 5'($urandom_range(0, 7)); ex_result = $urandom;
    wb_regWrite = 1'($urandom_range(0, 1));
    wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
    ex_stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 15) == 0);
    #1;
    hz = hazard();
    chk($sformatf("rand%0d_ready", n), 32'(id_ready), 32'(flush || (!ex_stall && !hz)));
    if (flush) m_valid = 0;
    else if (!ex_stall) begin
      if (hz) begin
        m_valid = 0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_valid = id_valid; m_ua = id_rs1_used; m_ub = id_rs2_used;
        m_a = arch_val(id_rs1, rf_dataA); m_b = arch_val(id_rs2, rf_dataB);
        m_rd = id_rd; m_ctrl = id_ctrl; m_imm = id_imm; m_pc = id_pc;
      end
    end
    if (wb_regWrite && wb_rd != 0) rf[wb_rd] = wb_data;
    edge1();
    chk($sformatf("rand%0d_valid", n), 32'(out_valid), 32'(m_valid));
    chk($sformatf("rand%0d_count", n), stall_count, m_cnt);
    if (m_valid) begin
      chk($sformatf("rand%0d_rd", n), 32'(out_rd), 32'(m_rd));
      chk($sformatf("rand%0d_ctrl", n), 32'(out_ctrl), 32'(m_ctrl));
      chk($sformatf("rand%0d_imm", n), out_imm, m_imm);
      chk($sformatf("rand%0d_pc", n), out_pc, m_pc);
      if (m_ua) chk($sformatf("rand%0d_opA", n), out_opA, m_a);
      if (m_ub) chk($sformatf("rand%0d_opB", n), out_opB, m_b);
    end
  endtask

  initial begin
    //      rs1 rs2 u1 u2 rfa        rfb        exv exw exm exrd exres    wbw wbrd wbd      rdy   vld   a        b
    vt[0] = '{5, 0, 1, 0, 32'h0,     32'h0,     1, 1, 0, 5,  32'h11,   0, 0, 32'h0,     FWD,  FWD,  32'h11,  32'h0};
    vt[1] = '{0, 7, 0, 1, 32'h0,     32'h55,    0, 0, 0, 0,  32'h0,    1, 7, 32'hAB,    FWD,  FWD,  32'h0,   32'hAB};
    vt[2] = '{0, 0, 1, 0, 32'h99,    32'h0,     1, 1, 0, 0,  32'hFF,   0, 0, 32'h0,     1'b1, 1'b1, 32'h0,   32'h0};
    vt[3] = '{3, 4, 1, 1, 32'h1234,  32'h5678,  0, 0, 0, 0,  32'h0,    0, 0, 32'h0,     1'b1, 1'b1, 32'h1234, 32'h5678};
    vt[4] = '{3, 0, 1, 0, 32'h0,     32'h0,     1, 1, 1, 3,  32'h33,   0, 0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0};
    vt[5] = '{6, 0, 1, 0, 32'h44,    32'h0,     1, 1, 0, 6,  32'h22,   1, 6, 32'h33,    FWD,  FWD,  32'h22,  32'h0};
    vt[6] = '{3, 4, 0, 1, 32'h0,     32'h5678,  1, 1, 1, 3,  32'h0,    0, 0, 32'h0,     1'b1, 1'b1, 32'h0,   32'h5678};
    vt[7] = '{9, 0, 1, 0, 32'h900,   32'h0,     0, 1, 0, 9,  32'hDEAD, 0, 0, 32'h0,     1'b1, 1'b1, 32'h900, 32'h0};
    vt[8] = '{0, 2, 1, 1, 32'h0,     32'h20,    1, 1, 1, 0,  32'h0,    0, 0, 32'h0,     1'b1, 1'b1, 32'h0,   32'h20};
    vt[9] = '{0, 8, 0, 1, 32'h0,     32'h80,    0, 0, 0, 0,  32'h0,    0, 8, 32'h888,   1'b1, 1'b1, 32'h0,   32'h80};

    idle();
    clear = 1;
    #12;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_opA", out_opA, 32'h0);
    chk("reset_count", stall_count, 32'h0);
    chk("reset_pc", out_pc, 32'h0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      idle();
      id_valid = 1;
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_rs1_used = vt[i].u1; id_rs2_used = vt[i].u2;
      rf_dataA = vt[i].rfa; rf_dataB = vt[i].rfb;
      ex_valid = vt[i].exv; ex_regWrite = vt[i].exw; ex_memRead = vt[i].exm;
      ex_rd = vt[i].exrd; ex_result = vt[i].exres;
      wb_regWrite = vt[i].wbw; wb_rd = vt[i].wbrd; wb_data = vt[i].wbd;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(id_ready), 32'(vt[i].rdy));
      edge1();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].vld));
      if (vt[i].vld && vt[i].u1) chk($sformatf("vec%0d_opA", i), out_opA, vt[i].a);
      if (vt[i].vld && vt[i].u2) chk($sformatf("vec%0d_opB", i), out_opB, vt[i].b);
    end

    // Load-use: bubble, then issue once the load result is reachable.
    do_reset();
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1; rf_dataA = 0;
    ex_valid = 1; ex_regWrite = 1; ex_memRead = 1; ex_rd = 3;
    #1;
    chk("lu_ready", 32'(id_ready), 32'h0);
    edge1();
    chk("lu_bubble", 32'(out_valid), 32'h0);
    chk("lu_count", stall_count, 32'd1);
    ex_valid = 0; ex_memRead = 0; ex_regWrite = 0;
    wb_regWrite = 1; wb_rd = 3; wb_data = 32'h77;
    #1;
`ifndef ID_EX_FWD_EN
    chk("lu_wb_wait", 32'(id_ready), 32'h0);
    edge1();
    chk("lu_wb_bubble", 32'(out_valid), 32'h0);
    chk("lu_wb_count", stall_count, 32'd2);
    wb_regWrite = 0; rf_dataA = 32'h77;
    #1;
`endif
    chk("lu_ready2", 32'(id_ready), 32'h1);
    edge1();
    chk("lu_issue", 32'(out_valid), 32'h1);
    chk("lu_opA", out_opA, 32'h77);
    chk("lu_count_hold", stall_count, FWD ? 32'd1 : 32'd2);

    // EX backpressure holds the stage, then flush wins over ex_stall.
    do_reset();
    id_valid = 1; id_rs1 = 3; id_rs2 = 4; id_rs1_used = 1; id_rs2_used = 1;
    rf_dataA = 32'h1234; rf_dataB = 32'h5678; id_rd = 9; id_ctrl = 16'hBEEF;
    id_imm = 32'h10; id_pc = 32'h400;
    edge1();
    chk("hold_cap", 32'(out_valid), 32'h1);
    ex_stall = 1; rf_dataA = 32'hFFFF; id_pc = 32'h500; id_rd = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_ready", k), 32'(id_ready), 32'h0);
      edge1();
      chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("hold%0d_opA", k), out_opA, 32'h1234);
      chk($sformatf("hold%0d_opB", k), out_opB, 32'h5678);
      chk($sformatf("hold%0d_pc", k), out_pc, 32'h400);
      chk($sformatf("hold%0d_rd", k), 32'(out_rd), 32'd9);
    end
    flush = 1;
    #1;
    chk("flush_ready", 32'(id_ready), 32'h1);
    edge1();
    chk("flush_valid", 32'(out_valid), 32'h0);

    // Asynchronous clear between edges while the stage is busy.
    do_reset();
    id_valid = 1; id_rs1 = 2; id_rs1_used = 1;
    ex_valid = 1; ex_regWrite = 1; ex_memRead = 1; ex_rd = 2;
    edge1();
    idle();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; rf_dataA = 32'hCAFE; id_pc = 32'h88;
    id_ctrl = 16'h1; id_imm = 32'h3; id_rd = 4;
    edge1();
    chk("pre_clr_valid", 32'(out_valid), 32'h1);
    chk("pre_clr_count", stall_count, 32'd1);
    #2;
    clear = 1;
    #1;
    chk("clr_valid", 32'(out_valid), 32'h0);
    chk("clr_opA", out_opA, 32'h0);
    chk("clr_pc", out_pc, 32'h0);
    chk("clr_ctrl", 32'(out_ctrl), 32'h0);
    chk("clr_imm", out_imm, 32'h0);
    chk("clr_rd", 32'(out_rd), 32'h0);
    chk("clr_count", stall_count, 32'h0);
    #2;
    clear = 0;

    // Randomized run against the reference model.
    do_reset();
    m_valid = 0; m_ua = 0; m_ub = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
    m_cnt = 0; m_rd = 0; m_ctrl = 0;
    rf[0] = 0;
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
    for (int n = 0; n < 1500; n++) rand_cycle(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the register file.
- Takes the decoded instruction plus the register file's dataA/dataB read data.
- Resolves RAW hazards by forwarding from EX and WB, and detects load-use hazards by stalling plus bubble insertion.
- Latches resolved operands and control into the ID/EX pipeline register feeding the ALU.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width.
- CTRL_W, 16, opaque decoded control bundle width.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous, active-high reset
- id_valid  input  1  decode holds a valid instruction
- id_ready  output  1  stage accepts the decode instruction this cycle
- id_rs1  input  AW  source 1 address (also drives regfile addrA)
- id_rs2  input  AW  source 2 address (also drives regfile addrB)
- id_rs1_used  input  1  instruction reads rs1
- id_rs2_used  input  1  instruction reads rs2
- id_rd  input  AW  destination address
- id_ctrl  input  CTRL_W  decoded control
- id_imm  input  XLEN  immediate
- id_pc  input  XLEN  instruction PC
- rf_dataA  input  XLEN  regfile read port A
- rf_dataB  input  XLEN  regfile read port B
- ex_valid  input  1  EX holds a valid instruction
- ex_regWrite  input  1  EX instruction writes rd
- ex_memRead  input  1  EX instruction is a load
- ex_rd  input  AW  EX destination
- ex_result  input  XLEN  EX ALU result
- wb_regWrite  input  1  WB write enable (same signal as regfile regWriteEnable)
- wb_rd  input  AW  WB destination (regfile addrD)
- wb_data  input  XLEN  WB data (regfile dataD)
- ex_stall  input  1  EX cannot accept a new instruction
- flush  input  1  kill ID and stage contents (branch/jump taken)
- out_valid  output  1  registered valid to EX
- out_opA  output  XLEN  registered resolved operand 1
- out_opB  output  XLEN  registered resolved operand 2
- out_rd  output  AW  registered destination
- out_ctrl  output  CTRL_W  registered control
- out_imm  output  XLEN  registered immediate
- out_pc  output  XLEN  registered PC
- stall_count  output  32  load-use stall cycles since reset

Behaviour:
- Reset: clear high asynchronously zeroes every registered output, including stall_count. id_ready is combinational.
- Latency: one cycle, from id_valid && id_ready to out_valid.
- Per-operand forwarding, in priority order:
  - Address 0 resolves to 0.
  - Otherwise, if ex_valid && ex_regWrite && !ex_memRead && ex_rd == rs, use ex_result.
  - Otherwise, if wb_regWrite && wb_rd == rs, use wb_data. This covers the regfile's same-edge write, where the combinational read would be stale.
  - Otherwise, use rf_dataA/rf_dataB.
  - An unused operand still passes through the mux; its value is don't-care.
- load_use = id_valid && ex_valid && ex_memRead && ex_rd != 0 && ((id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2)).
- id_ready = flush || (!ex_stall && !load_use).
- Register update at each rising edge:
  - flush: out_valid <= 0. Other fields are don't-care. flush beats ex_stall and load_use.
  - else ex_stall: hold all outputs unchanged. Operands latched earlier remain correct.
  - else load_use: out_valid <= 0 (bubble); stall_count increments, saturating at all-ones.
  - else: capture resolved operands and id fields; out_valid <= id_valid.
- A WB write to the same register in the capture cycle is always taken via the forward, never from the stale regfile value.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding network as above.
- Undefined: no EX/WB forwarding paths; operands come only from the regfile, with x0 forced to 0.
  - Hazard condition widens to any RAW against ex_valid && ex_regWrite && ex_rd != 0.
  - It also covers any RAW against wb_regWrite && wb_rd != 0.
  - Bubble and stall_count behave as for load_use.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and AW constants.
  - fwd_sel_t enum: FWD_ZERO, FWD_EX, FWD_WB, FWD_RF.
- Sub-module operand_fwd_mux: one operand's select logic plus mux. Instantiated twice.

Test Plan:
- EX add to x5 with ex_result=0x11; ID reads rs1=x5; regfile returns 0 -> out_opA=0x11 one cycle later.
- WB writing x7=0xAB the same cycle ID reads rs2=x7 -> out_opB=0xAB, not the stale regfile value.
- EX load to x3; ID uses rs1=x3 -> id_ready=0; next cycle out_valid=0 and stall_count=1; after EX advances, the instruction issues with the forwarded value.
- rs1=x0 while EX writes x0=0xFF -> out_opA=0.
- ex_stall held 3 cycles with a valid instruction in the stage -> outputs constant and id_ready=0; then flush and ex_stall together -> out_valid=0 next edge.
- clear asserted mid-stream, asynchronous between edges -> all outputs 0 immediately, including stall_count.
